// File: rtl/ex_operand_if.sv
// ex_operand_if: bundles the decode-side inputs, forwarding sources and
// execute-side outputs of the ID/EX operand stage.
//   master : decode / pipeline side (drives id_*, exmem_*, memwb_*, ex_hold, flush)
//   slave  : ex_operand_stage (drives alu_*, ex_*, stall_id)
interface ex_operand_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);
    // Decode stage
    logic              id_valid;
    logic [REG_AW-1:0] id_rs_addr;
    logic [REG_AW-1:0] id_rt_addr;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_use_imm;
    logic [2:0]        id_aluop;
    logic              id_unsig;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_regwrite;
    logic              id_memread;
    // Forwarding sources
    logic              exmem_regwrite;
    logic [REG_AW-1:0] exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_regwrite;
    logic [REG_AW-1:0] memwb_rd;
    logic [DATA_W-1:0] memwb_result;
    // Pipeline control
    logic              ex_hold;
    logic              flush;
    // Execute stage
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic              alu_unsig;
    logic [DATA_W-1:0] ex_store_data;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              stall_id;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
               id_use_imm, id_aluop, id_unsig, id_rd_addr, id_regwrite, id_memread,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result, ex_hold, flush,
        input  alu_a, alu_b, alu_op, alu_unsig, ex_store_data, ex_valid, ex_rd,
               ex_regwrite, ex_memread, stall_id
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
               id_use_imm, id_aluop, id_unsig, id_rd_addr, id_regwrite, id_memread,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result, ex_hold, flush,
        output alu_a, alu_b, alu_op, alu_unsig, ex_store_data, ex_valid, ex_rd,
               ex_regwrite, ex_memread, stall_id
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with operand forwarding.
// Captures decoded operands, forwards from EX/MEM (first) and MEM/WB (second),
// inserts one bubble on a load-use hazard, and honours ex_hold and flush.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : ex_operand_if slave (decode inputs, forwarding sources, Alu outputs)
module ex_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input logic         clk,
    input logic         rst,
    ex_operand_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic [2:0]        op;
        logic              unsig;
        logic              regwrite;
        logic              memread;
    } ex_regs_t;

    ex_regs_t ex_q, ex_d;

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_rt;
    logic              load_use;

    // Forwarding: MEM/WB assigned first so a matching EX/MEM overrides it.
    always_comb begin
        fwd_a  = ex_q.rs_data;
        fwd_rt = ex_q.rt_data;
        if (bus.memwb_regwrite && (bus.memwb_rd != '0)) begin
            if (bus.memwb_rd == ex_q.rs_addr) fwd_a  = bus.memwb_result;
            if (bus.memwb_rd == ex_q.rt_addr) fwd_rt = bus.memwb_result;
        end
        if (bus.exmem_regwrite && (bus.exmem_rd != '0)) begin
            if (bus.exmem_rd == ex_q.rs_addr) fwd_a  = bus.exmem_result;
            if (bus.exmem_rd == ex_q.rt_addr) fwd_rt = bus.exmem_result;
        end
    end

    // rt is only a real dependency when the instruction does not use the immediate.
    assign load_use = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && bus.id_valid &&
                      ((bus.id_rs_addr == ex_q.rd) ||
                       (!bus.id_use_imm && (bus.id_rt_addr == ex_q.rd)));

    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d.valid    = 1'b0;
            ex_d.regwrite = 1'b0;
            ex_d.memread  = 1'b0;
        end else if (bus.ex_hold) begin
            // Refresh operands so they survive the producer leaving MEM/WB.
            ex_d.rs_data = fwd_a;
            ex_d.rt_data = fwd_rt;
        end else if (load_use) begin
            ex_d.valid    = 1'b0;
            ex_d.regwrite = 1'b0;
            ex_d.memread  = 1'b0;
        end else begin
            ex_d.valid    = bus.id_valid;
            ex_d.rs_addr  = bus.id_rs_addr;
            ex_d.rt_addr  = bus.id_rt_addr;
            ex_d.rd       = bus.id_rd_addr;
            ex_d.rs_data  = bus.id_rs_data;
            ex_d.rt_data  = bus.id_rt_data;
            ex_d.imm      = bus.id_imm;
            ex_d.use_imm  = bus.id_use_imm;
            ex_d.op       = bus.id_aluop;
            ex_d.unsig    = bus.id_unsig;
            ex_d.regwrite = bus.id_regwrite && bus.id_valid;
            ex_d.memread  = bus.id_memread && bus.id_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.alu_a         = fwd_a;
    assign bus.alu_b         = ex_q.use_imm ? ex_q.imm : fwd_rt;
    assign bus.alu_op        = ex_q.op;
    assign bus.alu_unsig     = ex_q.unsig;
    assign bus.ex_store_data = fwd_rt;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_regwrite   = ex_q.valid && ex_q.regwrite;
    assign bus.ex_memread    = ex_q.valid && ex_q.memread;
    // Held low during reset so a lingering ex_hold cannot stall decode.
    assign bus.stall_id      = !rst && !bus.flush && (bus.ex_hold || load_use);

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage.
module tb_ex_operand_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ex_operand_if #(.DATA_W(32), .REG_AW(5)) bus ();

    ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic use_imm,
                            input logic [2:0] op, input logic [4:0] rd,
                            input logic rw, input logic mr);
        bus.id_valid    = v;
        bus.id_rs_addr  = rs;
        bus.id_rt_addr  = rt;
        bus.id_rs_data  = rsd;
        bus.id_rt_data  = rtd;
        bus.id_imm      = imm;
        bus.id_use_imm  = use_imm;
        bus.id_aluop    = op;
        bus.id_unsig    = 1'b0;
        bus.id_rd_addr  = rd;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
    endtask

    task automatic drive_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                             input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        bus.exmem_regwrite = ew;
        bus.exmem_rd       = erd;
        bus.exmem_result   = eres;
        bus.memwb_regwrite = mw;
        bus.memwb_rd       = mrd;
        bus.memwb_result   = mres;
    endtask

    initial begin
        drive_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        drive_fwd(0, 0, 0, 0, 0, 0);
        bus.ex_hold = 1'b0;
        bus.flush   = 1'b0;
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_reset_valid", bus.ex_valid, 0);
        chk("post_reset_stall", bus.stall_id, 0);

        // EX/MEM beats MEM/WB: add r3 = r1 + r2
        drive_id(1, 1, 2, 5, 7, 0, 0, 3'b010, 3, 1, 0);
        step();
        drive_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        drive_fwd(1, 1, 100, 1, 1, 200);
        #1;
        chk("prio_alu_a", bus.alu_a, 100);
        chk("prio_alu_b", bus.alu_b, 7);
        chk("prio_alu_op", bus.alu_op, 3'b010);
        chk("prio_ex_valid", bus.ex_valid, 1);
        chk("prio_ex_rd", bus.ex_rd, 3);
        chk("prio_regwrite", bus.ex_regwrite, 1);
        drive_fwd(0, 0, 0, 1, 1, 200);
        #1;
        chk("memwb_alu_a", bus.alu_a, 200);

        // Asynchronous reset mid-cycle while EX is valid
        drive_fwd(0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.ex_valid, 0);
        chk("arst_alu_a", bus.alu_a, 0);
        chk("arst_alu_b", bus.alu_b, 0);
        chk("arst_alu_op", bus.alu_op, 0);
        chk("arst_regwrite", bus.ex_regwrite, 0);
        chk("arst_ex_rd", bus.ex_rd, 0);
        chk("arst_store", bus.ex_store_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Register 0 is never forwarded; immediate selects b
        drive_id(1, 0, 5, 0, 9, 32'h10, 1, 3'b000, 6, 1, 0);
        step();
        drive_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        drive_fwd(1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF);
        #1;
        chk("r0_alu_a", bus.alu_a, 0);
        chk("r0_alu_b_imm", bus.alu_b, 32'h10);
        chk("r0_store", bus.ex_store_data, 9);
        drive_fwd(0, 0, 0, 0, 0, 0);
        step();

        // Load-use: lw r4 then sub r5 = r4 - r6
        drive_id(1, 1, 0, 8, 0, 4, 1, 3'b010, 4, 1, 1);
        step();
        drive_id(1, 4, 6, 0, 3, 0, 0, 3'b110, 5, 1, 0);
        #1;
        chk("lu_stall", bus.stall_id, 1);
        chk("lu_memread", bus.ex_memread, 1);
        step();
        chk("lu_bubble_valid", bus.ex_valid, 0);
        chk("lu_bubble_rw", bus.ex_regwrite, 0);
        chk("lu_bubble_mr", bus.ex_memread, 0);
        chk("lu_stall_once", bus.stall_id, 0);
        step();
        drive_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        drive_fwd(0, 0, 0, 1, 4, 32'h1234);
        #1;
        chk("lu_alu_a", bus.alu_a, 32'h1234);
        chk("lu_alu_b", bus.alu_b, 3);
        chk("lu_alu_op", bus.alu_op, 3'b110);
        chk("lu_valid", bus.ex_valid, 1);
        drive_fwd(0, 0, 0, 0, 0, 0);
        step();

        // Hold refresh: add r7 = r1 + r2, r2 arrives from MEM/WB in held cycle 1 only
        drive_id(1, 1, 2, 11, 0, 0, 0, 3'b010, 7, 1, 0);
        step();
        drive_id(1, 9, 9, 999, 999, 0, 0, 3'b001, 8, 1, 0);
        bus.ex_hold = 1'b1;
        drive_fwd(0, 0, 0, 1, 2, 55);
        #1;
        chk("hold1_alu_b", bus.alu_b, 55);
        chk("hold1_stall", bus.stall_id, 1);
        step();
        drive_fwd(0, 0, 0, 0, 0, 0);
        #1;
        chk("hold2_alu_b", bus.alu_b, 55);
        chk("hold2_stall", bus.stall_id, 1);
        step();
        chk("hold3_alu_b", bus.alu_b, 55);
        chk("hold3_stall", bus.stall_id, 1);
        step();
        bus.ex_hold = 1'b0;
        #1;
        chk("rel_alu_b", bus.alu_b, 55);
        chk("rel_alu_a", bus.alu_a, 11);
        chk("rel_alu_op", bus.alu_op, 3'b010);
        chk("rel_valid", bus.ex_valid, 1);
        chk("rel_stall", bus.stall_id, 0);
        drive_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        step();

        // Hold together with load-use: hold wins, bubble follows
        drive_id(1, 1, 0, 8, 0, 4, 1, 3'b010, 4, 1, 1);
        step();
        drive_id(1, 4, 6, 0, 3, 0, 0, 3'b110, 5, 1, 0);
        bus.ex_hold = 1'b1;
        #1;
        chk("hlu_stall", bus.stall_id, 1);
        step();
        chk("hlu_frozen_valid", bus.ex_valid, 1);
        chk("hlu_frozen_mr", bus.ex_memread, 1);
        bus.ex_hold = 1'b0;
        #1;
        chk("hlu_stall_lu", bus.stall_id, 1);
        step();
        chk("hlu_bubble", bus.ex_valid, 0);
        drive_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        step();

        // Flush beats hold and load-use
        drive_id(1, 1, 0, 8, 0, 4, 1, 3'b010, 4, 1, 1);
        step();
        drive_id(1, 4, 6, 0, 3, 0, 0, 3'b110, 5, 1, 0);
        bus.ex_hold = 1'b1;
        bus.flush   = 1'b1;
        #1;
        chk("fl_stall", bus.stall_id, 0);
        chk("fl_pre_valid", bus.ex_valid, 1);
        step();
        chk("fl_valid", bus.ex_valid, 0);
        chk("fl_regwrite", bus.ex_regwrite, 0);
        chk("fl_memread", bus.ex_memread, 0);
        bus.ex_hold = 1'b0;
        bus.flush   = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding stage that drives the Alu inputs a, b, op and unsig.
- Captures decoded operands once per cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts one bubble.
- Honours downstream hold and branch flush.
- Sits between the decode stage and the Alu instance in the execute stage.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  decode holds a valid instruction
id_rs_addr  input  REG_AW  source register s
id_rt_addr  input  REG_AW  source register t
id_rs_data  input  DATA_W  register-file value of rs
id_rt_data  input  DATA_W  register-file value of rt
id_imm  input  DATA_W  sign/zero-extended immediate
id_use_imm  input  1  b operand = immediate instead of rt
id_aluop  input  3  Alu op code (000 and, 001 or, 010 add, 100 nor, 101 xor, 110 sub)
id_unsig  input  1  Alu unsig control
id_rd_addr  input  REG_AW  destination register
id_regwrite  input  1  instruction writes rd
id_memread  input  1  instruction is a load
exmem_regwrite  input  1  EX/MEM writes back
exmem_rd  input  REG_AW  EX/MEM destination
exmem_result  input  DATA_W  EX/MEM Alu result
memwb_regwrite  input  1  MEM/WB writes back
memwb_rd  input  REG_AW  MEM/WB destination
memwb_result  input  DATA_W  MEM/WB writeback value
ex_hold  input  1  downstream stall; freeze EX
flush  input  1  branch taken; kill ID and EX contents
alu_a  output  DATA_W  forwarded operand a to Alu
alu_b  output  DATA_W  operand b (immediate or forwarded rt)
alu_op  output  3  registered op to Alu
alu_unsig  output  1  registered unsig to Alu
ex_store_data  output  DATA_W  forwarded rt, for stores
ex_valid  output  1  EX holds a valid instruction
ex_rd  output  REG_AW  registered rd
ex_regwrite  output  1  registered regwrite, gated by ex_valid
ex_memread  output  1  registered memread, gated by ex_valid
stall_id  output  1  decode must hold its instruction

Behaviour:
- Reset (asynchronous, any time, including mid-hold):
  - All EX registers clear to 0; ex_valid=0, alu_op=000, alu_unsig=0, ex_rd=0.
  - alu_a=alu_b=ex_store_data=0; stall_id=0.
- Latency: an instruction accepted at edge N appears on the alu_* outputs after edge N. The Alu result is combinational in the same cycle.
- Forwarding (combinational on the registered ex_rs/ex_rt):
  - Priority 1: EX/MEM, when exmem_regwrite and exmem_rd!=0 and the address matches.
  - Priority 2: MEM/WB, when memwb_regwrite and memwb_rd!=0 and the address matches.
  - Otherwise: the registered data.
  - Register 0 is never forwarded.
  - alu_b = registered imm when use_imm=1, else forwarded rt.
- Load-use hazard (load_use):
  - Condition: ex_valid and ex_memread and ex_rd!=0 and id_valid, and either id_rs_addr==ex_rd, or (id_use_imm=0 and id_rt_addr==ex_rd).
  - Response: stall_id=1; at the next edge EX loads a bubble (ex_valid=0, regwrite=memread=0) and decode holds.
  - Exactly one bubble cycle per load.
- Hold (ex_hold=1):
  - EX control registers are frozen; stall_id=1.
  - Every held cycle, ex_rs_data/ex_rt_data are overwritten with the currently forwarded values, so operands stay correct after the producer retires from MEM/WB.
- Flush:
  - Highest priority over hold and load_use.
  - Next edge: ex_valid=0, ex_regwrite=0, ex_memread=0.
  - stall_id=0 during flush.
- Normal advance (no flush, no hold, no load_use): capture id_* into EX; ex_valid<=id_valid.
- Rule: stall_id = !flush && (ex_hold || load_use).
- Invalid EX contents: control outputs are gated to 0; alu_* values are don't-care but deterministic.
- Simultaneous load_use and ex_hold: hold wins; the bubble is inserted on the first non-held edge.

Test Plan:
- Reset: assert rst mid-cycle while ex_valid=1 -> all outputs 0 immediately, before the next clk edge.
- EX/MEM priority: ID add r3=r1+r2 (rs_data=5, rt_data=7). While in EX, exmem (rd=1, 100) and memwb (rd=1, 200) both match -> alu_a=100, alu_b=7, alu_op=010.
- Register 0: exmem_rd=0, exmem_regwrite=1, exmem_result=0xFFFFFFFF, rs=0, id_rs_data=0 -> alu_a=0.
- Load-use: lw r4 in EX (memread=1), ID sub uses r4 -> stall_id=1 one cycle, then ex_valid=0 bubble. Next cycle, memwb (rd=4, 0x1234) -> alu_a=0x1234, alu_op=110.
- Hold refresh: hold 3 cycles with memwb (rd=2, 55) present only in cycle 1 -> alu_b stays 55 through release, stall_id=1 for all 3 cycles.
- Flush priority: flush=1 together with ex_hold=1 and load_use -> next edge ex_valid=0, ex_regwrite=0, and stall_id=0 during flush.
